// File: rtl/cycle_checker_pkg.sv
// cycle_checker_pkg: run-state encoding and checkpoint entry sizing shared by the checker and its table.
package cycle_checker_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int entry_width(input int cnt_w, input int addr_w);
        return cnt_w + addr_w;
    endfunction

    function automatic int num_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/check_table.sv
// check_table: checkpoint register file, one synchronous write port and one combinational read port.
module check_table #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset: checkpoint contents survive a reset of the checker.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/cycle_checker.sv
// cycle_checker: compares the observed PC against a table of (cycle, address) checkpoints during a run.
module cycle_checker import cycle_checker_pkg::*; #(
    parameter int NUM_CHECKS = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [ADDR_WIDTH-1:0]         pc,
    input  logic                          cfg_wr_en,
    input  logic [$clog2(NUM_CHECKS)-1:0] cfg_idx,
    input  logic [CNT_WIDTH-1:0]          cfg_cycle,
    input  logic [ADDR_WIDTH-1:0]         cfg_addr,
    input  logic [$clog2(NUM_CHECKS):0]   cfg_num,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout,
    output logic [$clog2(NUM_CHECKS):0]   fail_count,
    output logic [$clog2(NUM_CHECKS)-1:0] first_fail_idx,
    output logic [CNT_WIDTH-1:0]          cycle_count
);

    localparam int IW = $clog2(NUM_CHECKS);
    localparam int NW = num_width(NUM_CHECKS);
    localparam int EW = entry_width(CNT_WIDTH, ADDR_WIDTH);

    state_t state, state_nx;
    logic [NW-1:0] ptr, num, ptr_adv, pend_left, fail_nx;
    logic [IW-1:0] first_nx;
    logic [EW-1:0] rd_entry;
    logic [CNT_WIDTH-1:0] ent_cycle;
    logic [ADDR_WIDTH-1:0] ent_addr;
    logic pending, reached, miss, all_done, at_max, tmo;

    check_table #(.DEPTH(NUM_CHECKS), .WIDTH(EW)) u_table (
        .clk     (clk),
        .wr_en   (cfg_wr_en && state != RUN),
        .wr_idx  (cfg_idx),
        .wr_data ({cfg_cycle, cfg_addr}),
        .rd_idx  (ptr[IW-1:0]),
        .rd_data (rd_entry)
    );

    assign {ent_cycle, ent_addr} = rd_entry;
    assign busy = state == RUN;
    assign done = state == DONE;

    // An entry is consumed once its cycle is reached or already passed; a passed cycle is a miss.
    always_comb begin
        pending   = ptr < num;
        reached   = pending && ent_cycle <= cycle_count;
        miss      = reached && (ent_cycle != cycle_count || pc != ent_addr);
        ptr_adv   = ptr + NW'(reached);
        all_done  = ptr_adv >= num;
        at_max    = &cycle_count;
        tmo       = at_max && !all_done;
        pend_left = tmo ? num - ptr_adv : '0;
        fail_nx   = fail_count + pend_left + NW'(miss);
        first_nx  = fail_count != '0 ? first_fail_idx :
                    miss ? ptr[IW-1:0] :
                    tmo ? ptr_adv[IW-1:0] : first_fail_idx;
        state_nx  = state == IDLE ? (start ? RUN : IDLE) :
                    state == RUN ? ((abort || all_done || tmo) ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr            <= '0;
            num            <= '0;
            fail_count     <= '0;
            first_fail_idx <= '1;
            cycle_count    <= '0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
        end else if (state == IDLE && start) begin
            ptr            <= '0;
            num            <= cfg_num;
            fail_count     <= '0;
            first_fail_idx <= '1;
            cycle_count    <= '0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
        end else if (state == RUN) begin
            cycle_count <= at_max ? cycle_count : cycle_count + CNT_WIDTH'(1);
            // Abort freezes the scoreboard; pass and timeout stay at their cleared values.
            if (!abort) begin
                ptr            <= ptr_adv;
                fail_count     <= fail_nx;
                first_fail_idx <= first_nx;
                pass           <= all_done && fail_nx == '0;
                timeout        <= tmo;
            end
        end
    end

endmodule

// File: tb/tb_cycle_checker.sv
// tb_cycle_checker: directed vectors and randomized runs on a default and a 4-bit-counter instance,
// with results predicted from each entry's scheduled check cycle.
module tb_cycle_checker;

    typedef struct {
        bit dut;
        int num;
        int c0, a0, c1, a1, c2, a2;
        int bad;
        int ab;
        bit ps, to;
        int fc, ff, e, cc;
    } vec_t;

    logic clk = 1'b0;
    logic reset, start, abort, cfg_wr_en;
    logic [15:0] pc, cfg_cycle, cfg_addr;
    logic [2:0] cfg_idx;
    logic [3:0] cfg_num;
    logic m_busy, m_done, m_pass, m_tmo;
    logic [3:0] m_fail;
    logic [2:0] m_first;
    logic [15:0] m_cc;
    logic w_busy, w_done, w_pass, w_tmo;
    logic [2:0] w_fail;
    logic [1:0] w_first;
    logic [3:0] w_cc;

    int n_vec = 0;
    int n_bad = 0;
    int tc[8], ta[8], pcs[64];
    int got_e[2];
    logic [31:0] got_ps[2], got_to[2], got_fc[2], got_ff[2], got_cc[2];
    vec_t v[12];
    int rn, rab, e, fc, ff, cc;
    bit ps, to, seen;

    always #5 clk = ~clk;

    cycle_checker u_main (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .pc(pc),
        .cfg_wr_en(cfg_wr_en), .cfg_idx(cfg_idx), .cfg_cycle(cfg_cycle), .cfg_addr(cfg_addr),
        .cfg_num(cfg_num), .busy(m_busy), .done(m_done), .pass(m_pass), .timeout(m_tmo),
        .fail_count(m_fail), .first_fail_idx(m_first), .cycle_count(m_cc)
    );

    cycle_checker #(.NUM_CHECKS(4), .ADDR_WIDTH(16), .CNT_WIDTH(4)) u_narrow (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .pc(pc),
        .cfg_wr_en(cfg_wr_en), .cfg_idx(cfg_idx[1:0]), .cfg_cycle(cfg_cycle[3:0]), .cfg_addr(cfg_addr),
        .cfg_num(cfg_num[2:0]), .busy(w_busy), .done(w_done), .pass(w_pass), .timeout(w_tmo),
        .fail_count(w_fail), .first_fail_idx(w_first), .cycle_count(w_cc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int k, input logic [31:0] got, input int exp);
        n_vec++;
        if (got !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0d expected %0d", nm, k, got, exp);
        end
    endtask

    task automatic check_res(input int k, input int xe, input bit xps, input bit xto,
                             input int xfc, input int xff, input int xcc);
        check("end_cycle", k, 32'(got_e[k]), xe);
        check("pass", k, got_ps[k], int'(xps));
        check("timeout", k, got_to[k], int'(xto));
        check("fail_count", k, got_fc[k], xfc);
        check("first_fail_idx", k, got_ff[k], xff);
        check("cycle_count", k, got_cc[k], xcc);
    endtask

    task automatic load_table(input int n);
        for (int i = 0; i < n; i++) begin
            cfg_wr_en = 1'b1;
            cfg_idx   = 3'(i);
            cfg_cycle = 16'(tc[i]);
            cfg_addr  = 16'(ta[i]);
            tick();
        end
        cfg_wr_en = 1'b0;
    endtask

    // Runs both instances; mid pulses start and a table write while running.
    task automatic do_run(input int n, input int ab, input bit sa, input int mid);
        cfg_num = 4'(n);
        start = 1'b1;
        abort = sa;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("busy_after_start", 0, 32'(m_busy), 1);
        got_e[0] = -1;
        got_e[1] = -1;
        for (int c = 0; c < 80 && (got_e[0] < 0 || got_e[1] < 0); c++) begin
            pc        = c < 64 ? 16'(pcs[c]) : 16'h0;
            abort     = c == ab;
            start     = c == mid;
            cfg_wr_en = c == mid;
            cfg_idx   = 3'd1;
            cfg_cycle = 16'd13;
            cfg_addr  = 16'h1234;
            tick();
            abort = 1'b0;
            start = 1'b0;
            cfg_wr_en = 1'b0;
            if (m_done && got_e[0] < 0) begin
                got_e[0] = c; got_ps[0] = 32'(m_pass); got_to[0] = 32'(m_tmo);
                got_fc[0] = 32'(m_fail); got_ff[0] = 32'(m_first); got_cc[0] = 32'(m_cc);
            end
            if (w_done && got_e[1] < 0) begin
                got_e[1] = c; got_ps[1] = 32'(w_pass); got_to[1] = 32'(w_tmo);
                got_fc[1] = 32'(w_fail); got_ff[1] = 32'(w_first); got_cc[1] = 32'(w_cc);
            end
        end
        tick();
    endtask

    // Entry i is checked at the later of its own cycle and one past the previous entry's check.
    function automatic void model(input int maxc, input int n, input int ab, input int iw,
                                  output int xe, output bit xps, output bit xto,
                                  output int xfc, output int xff, output int xcc);
        int rr[8];
        int prev = -1;
        bit abt;
        for (int i = 0; i < n; i++) begin
            rr[i] = (tc[i] & maxc) > prev ? (tc[i] & maxc) : prev + 1;
            prev = rr[i];
        end
        xto = n > 0 && prev > maxc;
        xe = n == 0 ? 0 : xto ? maxc : prev;
        abt = ab >= 0 && ab <= xe;
        if (abt) begin
            xe = ab;
            xto = 1'b0;
        end
        xfc = 0;
        xff = -1;
        for (int i = 0; i < n; i++) begin
            if (rr[i] < xe || (rr[i] == xe && !abt)) begin
                if (rr[i] != (tc[i] & maxc) || pcs[rr[i]] != ta[i]) begin
                    xfc++;
                    if (xff < 0) xff = i;
                end
            end else if (xto) begin
                xfc++;
                if (xff < 0) xff = i;
            end
        end
        xps = !abt && !xto && xfc == 0;
        if (xfc == 0) xff = (1 << iw) - 1;
        xcc = xe < maxc ? xe + 1 : maxc;
    endfunction

    initial begin
        v[0]  = '{0, 2, 9, 'h8000, 13, 'h8003, 0, 0, 0, -1, 1, 0, 0, 7, 13, 14};
        v[1]  = '{0, 2, 9, 'h8000, 13, 'h8003, 0, 0, 2, -1, 0, 0, 1, 1, 13, 14};
        v[2]  = '{0, 3, 9, 'h8000, 13, 'h8003, 20, 'h8010, 0, 5, 0, 0, 0, 7, 5, 6};
        v[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 1, 0, 0, 7, 0, 1};
        v[4]  = '{0, 2, 10, 'h1111, 3, 'h2222, 0, 0, 0, -1, 0, 0, 1, 1, 11, 12};
        v[5]  = '{0, 2, 9, 'h8000, 13, 'h8003, 0, 0, 0, 13, 0, 0, 0, 7, 13, 14};
        v[6]  = '{0, 2, 5, 'hAAAA, 5, 'hAAAA, 0, 0, 0, -1, 0, 0, 1, 1, 6, 7};
        v[7]  = '{0, 2, 2, 'h0F0F, 4, 'hF0F0, 0, 0, 3, -1, 0, 0, 2, 0, 4, 5};
        v[8]  = '{1, 1, 20, 'h00A5, 0, 0, 0, 0, 0, -1, 1, 0, 0, 3, 4, 5};
        v[9]  = '{1, 2, 10, 'h00A5, 3, 'h00B6, 0, 0, 0, -1, 0, 0, 1, 1, 11, 12};
        v[10] = '{1, 3, 15, 'h00A5, 15, 'h00B6, 2, 'h00C7, 0, -1, 0, 1, 2, 1, 15, 15};
        v[11] = '{1, 2, 5, 'h00A5, 8, 'h00B6, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1};

        reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_wr_en = 1'b0;
        pc = '0; cfg_idx = '0; cfg_cycle = '0; cfg_addr = '0; cfg_num = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", 0, 32'(m_busy), 0);
        check("rst_done", 0, 32'(m_done), 0);
        check("rst_pass", 0, 32'(m_pass), 0);
        check("rst_timeout", 0, 32'(m_tmo), 0);
        check("rst_fail_count", 0, 32'(m_fail), 0);
        check("rst_first_fail_idx", 0, 32'(m_first), 7);
        check("rst_cycle_count", 0, 32'(m_cc), 0);

        for (int i = 0; i < 12; i++) begin
            tc[0] = v[i].c0; ta[0] = v[i].a0;
            tc[1] = v[i].c1; ta[1] = v[i].a1;
            tc[2] = v[i].c2; ta[2] = v[i].a2;
            for (int c = 0; c < 64; c++) pcs[c] = 0;
            for (int j = v[i].num - 1; j >= 0; j--)
                pcs[(v[i].dut ? tc[j] & 15 : tc[j]) & 63] = ta[j] ^ ((v[i].bad >> j) & 1);
            load_table(3);
            do_run(v[i].num, v[i].ab, 1'b0, -1);
            check_res(int'(v[i].dut), v[i].e, v[i].ps, v[i].to, v[i].fc, v[i].ff, v[i].cc);
        end

        for (int t = 0; t < 40; t++) begin
            rn  = $urandom_range(0, 4);
            rab = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 18)) : -1;
            for (int i = 0; i < 4; i++) begin
                tc[i] = $urandom_range(0, 15);
                ta[i] = $urandom_range(0, 65535);
            end
            for (int c = 0; c < 64; c++) pcs[c] = $urandom_range(0, 65535);
            for (int j = 3; j >= 0; j--)
                if ($urandom_range(0, 3) != 0) pcs[tc[j]] = ta[j];
            load_table(4);
            do_run(rn, rab, 1'b0, -1);
            model(65535, rn, rab, 3, e, ps, to, fc, ff, cc);
            check_res(0, e, ps, to, fc, ff, cc);
            model(15, rn, rab, 2, e, ps, to, fc, ff, cc);
            check_res(1, e, ps, to, fc, ff, cc);
        end

        tc[0] = 9; ta[0] = 'h8000; tc[1] = 13; ta[1] = 'h8003;
        for (int c = 0; c < 64; c++) pcs[c] = 0;
        pcs[9] = 'h8000;
        pcs[13] = 'h8003;
        load_table(2);
        cfg_num = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", 0, 32'(m_busy), 0);
        check("midrst_done", 0, 32'(m_done), 0);
        check("midrst_pass", 0, 32'(m_pass), 0);
        check("midrst_timeout", 0, 32'(m_tmo), 0);
        check("midrst_fail_count", 0, 32'(m_fail), 0);
        check("midrst_first_fail_idx", 0, 32'(m_first), 7);
        check("midrst_cycle_count", 0, 32'(m_cc), 0);
        check("midrst_busy", 1, 32'(w_busy), 0);
        seen = 1'b0;
        repeat (20) begin
            tick();
            seen = seen | m_done | w_done;
        end
        check("no_done_after_reset", 0, 32'(seen), 0);
        do_run(2, -1, 1'b0, -1);
        check_res(0, 13, 1'b1, 1'b0, 0, 7, 14);

        do_run(2, -1, 1'b0, 4);
        check_res(0, 13, 1'b1, 1'b0, 0, 7, 14);
        check_res(1, 13, 1'b1, 1'b0, 0, 3, 14);

        do_run(2, -1, 1'b1, -1);
        check_res(0, 13, 1'b1, 1'b0, 0, 7, 14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cycle_checker.md
CYCLE_CHECKER -- requirements
Module: cycle_checker

Interface
REQ-001 Parameter NUM_CHECKS, default 8: depth of the checkpoint table (2..64).
REQ-002 Parameter ADDR_WIDTH, default 16: width of the monitored PC and of expected addresses.
REQ-003 Parameter CNT_WIDTH, default 16: width of the cycle counter and of expected cycle values.
REQ-004 Port list SHALL be exactly REQ-005..REQ-018; clock and reset come first.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse; starts a run when IDLE.
REQ-008 abort  in  1  ends a run immediately.
REQ-009 pc  in  ADDR_WIDTH  processor program counter under observation.
REQ-010 cfg_wr_en  in  1  table write strobe.
REQ-011 cfg_idx  in  clog2(NUM_CHECKS)  table entry index.
REQ-012 cfg_cycle  in  CNT_WIDTH  expected cycle number for the entry.
REQ-013 cfg_addr  in  ADDR_WIDTH  expected PC value at that cycle.
REQ-014 cfg_num  in  clog2(NUM_CHECKS)+1  active entry count; sampled on start.
REQ-015 busy  out  1  high while RUN.
REQ-016 done  out  1  one-cycle pulse on RUN exit.
REQ-017 pass / timeout  out  1 each  result flags, held until the next start.
REQ-018 fail_count  out  clog2(NUM_CHECKS)+1;  first_fail_idx  out  clog2(NUM_CHECKS);  cycle_count  out  CNT_WIDTH.

Function
REQ-019 States SHALL be IDLE, RUN, DONE; DONE lasts exactly one cycle, then the block returns to IDLE.
REQ-020 IDLE + start SHALL move to RUN on the next edge, with cycle_count=0, entry pointer=0, fail_count=0, and pass/timeout cleared.
REQ-021 In RUN, cycle_count SHALL increment by 1 per clk.
REQ-022 In RUN, when cycle_count equals table[ptr].cycle, pc SHALL be compared to table[ptr].addr in that same cycle, and ptr SHALL advance.
REQ-023 On mismatch, fail_count SHALL increment; the first mismatching ptr SHALL be latched into first_fail_idx.
REQ-024 An entry whose cycle is below the current cycle_count (unsorted or duplicate entry) SHALL count as a mismatch when reached and SHALL advance ptr.
REQ-025 After ptr reaches the latched cfg_num, the block SHALL go to DONE; pass = (fail_count==0).
REQ-026 cfg_num=0 on start SHALL give RUN for one cycle, then DONE with pass=1.
REQ-027 If cycle_count would wrap past all-ones with entries pending: go to DONE with timeout=1 and pass=0; every pending entry SHALL be added to fail_count.
REQ-028 abort in RUN SHALL go to DONE with pass=0; pending entries are not counted.
REQ-029 start while RUN or DONE SHALL be ignored.
REQ-030 cfg_wr_en in RUN SHALL be ignored; in IDLE or DONE the write takes effect on the next edge.
REQ-031 start and abort in the same IDLE cycle: start wins. abort and final-entry completion in the same cycle: abort wins.
REQ-032 first_fail_idx SHALL be all-ones when fail_count==0.

Reset
REQ-033 reset SHALL put the block in IDLE with busy=0, done=0, pass=0, timeout=0, fail_count=0, first_fail_idx=all-ones, cycle_count=0, and ptr=0.
REQ-034 reset mid-RUN SHALL abandon the run with no done pulse.
REQ-035 Table contents SHALL NOT be cleared by reset.

Structure
REQ-036 Package cycle_checker_pkg SHALL hold the state encoding and the entry record (cycle, addr) width functions.
REQ-037 Sub-module check_table SHALL hold the NUM_CHECKS-deep register file, with 1 write port and 1 combinational read port.

Verification
REQ-038 Load entry0 = (9, 0x8000) and entry1 = (13, 0x8003); cfg_num=2; start; drive pc=0x8000 at cycle 9 and 0x8003 at cycle 13. Required: done at cycle 14, pass=1, fail_count=0.
REQ-039 Same table as REQ-038 with pc=0x8002 at cycle 13. Required: pass=0, fail_count=1, first_fail_idx=1.
REQ-040 CNT_WIDTH=4; entry0 cycle 20 (truncated to 4), entry1 cycle 3 after entry0 cycle 10. Required: entry1 counted as a mismatch; a run with unreachable entries ends with timeout=1 after 16 cycles.
REQ-041 abort at cycle 5 of a 3-entry run. Required: done pulse next cycle, pass=0, timeout=0.
REQ-042 reset asserted at cycle 7 of a run. Required: all outputs at reset values the next cycle, no done; a following run reuses the intact table and passes.
REQ-043 cfg_num=0 and start. Required: done one cycle after RUN entry, pass=1.
